// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: command controller behind spi_slave.
// Decodes 24-bit {cmd,addr,payload} frames, owns per-LED brightness registers
// (0..100), drives period-aligned PWM on the LED pins and stages read-back
// frames for the next CS transaction.
// Optional feature macro: LED_FADE_EN (level walks 1 step per PWM period
// toward its target instead of jumping straight to it).
module spi_led_ctrl #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned PWM_DIV  = 1250,
    parameter logic [7:0]  CMD_WR   = 8'h01,
    parameter logic [7:0]  CMD_RD   = 8'h02
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                rx_dv,
    input  logic [7:0]          i_cmd,
    input  logic [7:0]          i_addr,
    input  logic [7:0]          i_payload,
    output logic [23:0]         o_slv_frame,
    output logic                o_slv_tx_enb,
    output logic [NUM_LEDS-1:0] o_led,
    output logic                o_err,
    output logic                o_busy
);

    localparam int unsigned DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned LVL_W    = 7;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned FRAME_W  = 24;

    localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(100);
    localparam logic [LVL_W-1:0]   STEP_LAST = LVL_W'(99);
    localparam logic [FIELD_W-1:0] CMD_NOP   = 8'h00;
    localparam logic [DIV_W-1:0]   PRE_LAST  = DIV_W'(PWM_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_READ,
        ST_ERROR
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic                 rx_dv_q;
    logic [FIELD_W-1:0]   cmd_q;
    logic [FIELD_W-1:0]   addr_q;
    logic [FIELD_W-1:0]   payload_q;

    logic [FRAME_W-1:0]   frame_q;
    logic                 tx_enb_q;
    logic                 err_q;
    logic                 busy_q;

    logic [DIV_W-1:0]     pre_q;
    logic [LVL_W-1:0]     step_q;

    logic                 frame_evt_c;
    logic                 addr_ok_c;
    logic [IDX_W-1:0]     idx_c;
    logic [LVL_W-1:0]     clamp_c;
    logic                 tick_c;
    logic                 wrap_c;
    logic                 tgt_we_c;
    logic                 rd_we_c;
    logic                 err_c;

    logic [LVL_W-1:0]     level_vec [NUM_LEDS];

    // Frame event is a rising edge of rx_dv; history resets high so a held rx_dv is ignored
    assign frame_evt_c = rx_dv & ~rx_dv_q;
    assign addr_ok_c   = (32'(addr_q) < NUM_LEDS);
    assign idx_c       = addr_q[IDX_W-1:0];
    assign clamp_c     = (payload_q > 8'd100) ? LVL_MAX : payload_q[LVL_W-1:0];

    // PWM timebase strobes: step tick and period boundary (step 99 -> 0)
    assign tick_c = (pre_q == PRE_LAST);
    assign wrap_c = tick_c && (step_q == STEP_LAST);

    // FSM state register
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and per-state action strobes
    always_comb begin
        state_d  = state_q;
        tgt_we_c = 1'b0;
        rd_we_c  = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_evt_c) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cmd_q == CMD_NOP) begin
                    state_d = ST_IDLE;
                end else if (!addr_ok_c) begin
                    state_d = ST_ERROR;
                end else if (cmd_q == CMD_WR) begin
                    state_d = ST_WRITE;
                end else if (cmd_q == CMD_RD) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITE: begin
                tgt_we_c = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_READ: begin
                rd_we_c = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                err_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // rx_dv history and field capture on an accepted frame event
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            rx_dv_q   <= 1'b1;
            cmd_q     <= '0;
            addr_q    <= '0;
            payload_q <= '0;
        end else begin
            rx_dv_q <= rx_dv;
            if ((state_q == ST_IDLE) && frame_evt_c) begin
                cmd_q     <= i_cmd;
                addr_q    <= i_addr;
                payload_q <= i_payload;
            end
        end
    end

    // Status outputs: busy mirrors the next state, error is a single-cycle pulse
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            err_q  <= err_c;
        end
    end

    // Read-back staging: frame only rewritten on a read; any new frame event disarms tx
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            frame_q  <= '0;
            tx_enb_q <= 1'b0;
        end else if (rd_we_c) begin
            frame_q  <= {CMD_RD, addr_q, 1'b0, level_vec[idx_c]};
            tx_enb_q <= 1'b1;
        end else if (frame_evt_c) begin
            tx_enb_q <= 1'b0;
        end
    end

    // PWM prescaler and 0..99 step counter
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            step_q <= '0;
        end else if (tick_c) begin
            pre_q  <= '0;
            step_q <= (step_q == STEP_LAST) ? '0 : step_q + LVL_W'(1);
        end else begin
            pre_q  <= pre_q + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
        logic [LVL_W-1:0] target_q;
        logic [LVL_W-1:0] level_q;
        logic             led_q;

        // Brightness target, written by a valid write command (already clamped)
        always_ff @(posedge sysclk) begin
            if (!rst_n) begin
                target_q <= '0;
            end else if (tgt_we_c && (idx_c == IDX_W'(g))) begin
                target_q <= clamp_c;
            end
        end

        // Applied level only moves at a period boundary so no runt pulses appear
        always_ff @(posedge sysclk) begin
            if (!rst_n) begin
                level_q <= '0;
            end else if (wrap_c) begin
`ifdef LED_FADE_EN
                if (level_q < target_q) begin
                    level_q <= level_q + LVL_W'(1);
                end else if (level_q > target_q) begin
                    level_q <= level_q - LVL_W'(1);
                end
`else
                level_q <= target_q;
`endif
            end
        end

        // LED drive: high while step is below the applied level
        always_ff @(posedge sysclk) begin
            if (!rst_n) begin
                led_q <= 1'b0;
            end else begin
                led_q <= (step_q < level_q);
            end
        end

        assign level_vec[g] = level_q;
        assign o_led[g]     = led_q;
    end

    assign o_slv_frame  = frame_q;
    assign o_slv_tx_enb = tx_enb_q;
    assign o_err        = err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_spi_led_ctrl.sv
// Self-checking bench for spi_led_ctrl: randomized frames against a
// behavioural brightness model, with a scoreboard for read-back frames
// and error pulses, plus PWM duty measurements over whole periods.
module tb_spi_led_ctrl;

    localparam int unsigned NUM_LEDS = 4;
    localparam int unsigned PWM_DIV  = 3;
    localparam int unsigned PERIOD   = 100 * PWM_DIV;

    logic                sysclk = 1'b0;
    logic                rst_n  = 1'b0;
    logic                rx_dv  = 1'b1;
    logic [7:0]          i_cmd     = '0;
    logic [7:0]          i_addr    = '0;
    logic [7:0]          i_payload = '0;
    logic [23:0]         o_slv_frame;
    logic                o_slv_tx_enb;
    logic [NUM_LEDS-1:0] o_led;
    logic                o_err;
    logic                o_busy;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_frame_q [$];
    int          exp_err = 0;
    int          model_target [NUM_LEDS];
    int          model_level  [NUM_LEDS];
    bit          dirty        [NUM_LEDS];
    bit          expect_drop2 = 1'b0;
    int          cyc = 0;

    spi_led_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_DIV  (PWM_DIV)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .rx_dv        (rx_dv),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .o_slv_frame  (o_slv_frame),
        .o_slv_tx_enb (o_slv_tx_enb),
        .o_led        (o_led),
        .o_err        (o_err),
        .o_busy       (o_busy)
    );

    always #5 sysclk = ~sysclk;

    // Cycles since reset release, used only to keep directed sequences clear of period boundaries
    always @(posedge sysclk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a read frame or an error pulse
    logic        prev_tx    = 1'b0;
    logic        prev_err   = 1'b0;
    logic [23:0] prev_frame = '0;
    int          low_run    = 0;
    always @(negedge sysclk) begin
        if (!rst_n) begin
            prev_tx  = 1'b0;
            prev_err = 1'b0;
            low_run  = 0;
        end else begin
            if (o_err) begin
                check("err_single_cycle", 32'(prev_err), 32'd0);
                check("err_expected", 32'(exp_err > 0), 32'd1);
                if (exp_err > 0) exp_err--;
            end
            if (o_slv_tx_enb && !prev_tx) begin
                check("rd_frame_expected", 32'(exp_frame_q.size() > 0), 32'd1);
                if (exp_frame_q.size() > 0) begin
                    logic [23:0] e;
                    e = exp_frame_q.pop_front();
                    check("rd_frame", 32'(o_slv_frame), 32'(e));
                end
                if (expect_drop2) begin
                    check("tx_drop_cycles", 32'(low_run), 32'd2);
                    expect_drop2 = 1'b0;
                end
            end
            if (o_slv_tx_enb && prev_tx) begin
                check("frame_stable", 32'(o_slv_frame), 32'(prev_frame));
            end
            low_run    = o_slv_tx_enb ? 0 : low_run + 1;
            prev_tx    = o_slv_tx_enb;
            prev_err   = o_err;
            prev_frame = o_slv_frame;
        end
    end

    // One CS transaction: rx_dv low while shifting, then high with the fields valid
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        @(posedge sysclk); #1;
        rx_dv     = 1'b0;
        i_cmd     = 8'($urandom);
        i_addr    = 8'($urandom);
        i_payload = 8'($urandom);
        repeat (4) @(posedge sysclk);
        #1;
        if (c == 8'h00) begin
        end else if ((a >= 8'(NUM_LEDS)) || (c != 8'h01 && c != 8'h02)) begin
            exp_err++;
        end else if (c == 8'h01) begin
            model_target[a] = (p > 8'd100) ? 100 : int'(p);
            dirty[a]        = 1'b1;
        end else begin
            exp_frame_q.push_back({8'h02, a, 8'(model_level[a])});
        end
        i_cmd     = c;
        i_addr    = a;
        i_payload = p;
        rx_dv     = 1'b1;
        repeat (6) @(posedge sysclk);
    endtask

    // Let at least one period boundary pass with no writes: applied level equals target
    task automatic wait_period();
        repeat (PERIOD + 10) @(posedge sysclk);
        for (int i = 0; i < NUM_LEDS; i++) begin
            model_level[i] = model_target[i];
            dirty[i]       = 1'b0;
        end
    endtask

    // Wait until well inside a PWM period
    task automatic wait_safe();
        while (((cyc % PERIOD) < 20) || ((cyc % PERIOD) > 150)) @(posedge sysclk);
    endtask

    // Count high cycles of every LED over exactly one period
    task automatic check_duty();
        int cnt [NUM_LEDS];
        for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge sysclk);
            for (int i = 0; i < NUM_LEDS; i++) cnt[i] += int'(o_led[i]);
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            check($sformatf("duty_led%0d", i), 32'(cnt[i]), 32'(model_level[i] * PWM_DIV));
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            model_target[i] = 0;
            model_level[i]  = 0;
            dirty[i]        = 1'b0;
        end

        // Reset with rx_dv held high: release must not produce a frame event
        rst_n = 1'b0;
        rx_dv = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge sysclk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_led", 32'(o_led), 32'd0);
        check("rst_tx_enb", 32'(o_slv_tx_enb), 32'd0);
        check("rst_frame", 32'(o_slv_frame), 32'd0);

        // Half brightness on LED 2
        send_frame(8'h01, 8'h02, 8'h32);
        wait_period();
        check_duty();

        // Clamped write then read-back; tx stays armed until the next event
        send_frame(8'h01, 8'h01, 8'hC8);
        wait_period();
        send_frame(8'h02, 8'h01, 8'h00);
        repeat (20) @(negedge sysclk);
        check("tx_held", 32'(o_slv_tx_enb), 32'd1);
        check("frame_held", 32'(o_slv_frame), 32'h020164);

        // Bad address and unknown opcode: one error pulse each, nothing changes
        send_frame(8'h01, 8'h07, 8'h10);
        send_frame(8'h5A, 8'h00, 8'h00);
        check("tx_cleared", 32'(o_slv_tx_enb), 32'd0);
        send_frame(8'h00, 8'h09, 8'h55);
        wait_period();
        check_duty();

        // Back-to-back reads: tx drops for two cycles between them
        send_frame(8'h01, 8'h00, 8'h0A);
        wait_period();
        send_frame(8'h02, 8'h00, 8'h00);
        expect_drop2 = 1'b1;
        send_frame(8'h02, 8'h03, 8'h00);
        check("drop2_consumed", 32'(expect_drop2), 32'd0);

        // Read inside a period right after a write returns the applied level, not the target
        wait_safe();
        send_frame(8'h01, 8'h00, 8'h50);
        send_frame(8'h02, 8'h00, 8'h00);
        wait_period();
        send_frame(8'h02, 8'h00, 8'h00);

        // Randomized rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 30; k++) begin
                int          sel;
                logic [7:0]  a;
                sel = int'($urandom_range(0, 9));
                a   = 8'($urandom_range(0, NUM_LEDS - 1));
                case (sel)
                    0:       send_frame(8'h00, 8'($urandom), 8'($urandom));
                    1, 2, 3, 4, 5:
                             send_frame(8'h01, a, 8'($urandom));
                    6:       if (dirty[a]) send_frame(8'h01, a, 8'($urandom_range(0, 100)));
                             else          send_frame(8'h02, a, 8'($urandom));
                    7:       send_frame(8'($urandom_range(1, 2)), 8'($urandom_range(NUM_LEDS, 255)), 8'($urandom));
                    8:       send_frame(8'($urandom_range(3, 255)), a, 8'($urandom));
                    default: send_frame(8'h00, 8'($urandom_range(NUM_LEDS, 255)), 8'($urandom));
                endcase
            end
            wait_period();
            check_duty();
            for (int i = 0; i < NUM_LEDS; i++) begin
                send_frame(8'h02, 8'(i), 8'($urandom));
            end
        end

        repeat (20) @(negedge sysclk);
        check("frames_drained", 32'(exp_frame_q.size()), 32'd0);
        check("errs_drained", 32'(exp_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
